// File: rtl/fir_coeff_loader.sv
// Double-buffered FIR coefficient loader: beats fill a shadow bank that is committed atomically.
// Optional readback port of the active bank is enabled by defining FIR_COEFF_READBACK_EN.
module fir_coeff_loader #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_TAPS   = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic signed [DATA_WIDTH-1:0]   iv_coeff,
  input  logic                           i_coeff_valid,
  output logic                           o_coeff_ready,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights
`ifdef FIR_COEFF_READBACK_EN
  ,
  input  logic [$clog2(NUM_TAPS)-1:0]    i_rd_addr,
  output logic signed [DATA_WIDTH-1:0]   ov_rd_data
`endif
);

  localparam int IDX_W = $clog2(NUM_TAPS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                                r_state;
  state_t                                w_state_nxt;
  logic [IDX_W-1:0]                      r_index;
  logic                                  r_coeff_ready;
  logic                                  r_busy;
  logic                                  r_done;
  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]   r_shadow;
  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]   r_weights;
  logic                                  w_accept;
  logic                                  w_last;

  // Abort suppresses acceptance so a coincident final beat can never commit.
  assign w_accept = r_coeff_ready && i_coeff_valid && !i_abort;
  assign w_last   = (r_index == IDX_W'(NUM_TAPS - 1));

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_accept && w_last) begin
          w_state_nxt = ST_COMMIT;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered status outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_coeff_ready <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_coeff_ready <= (w_state_nxt == ST_LOAD);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_done        <= (r_state == ST_COMMIT);
    end
  end

  // Beat index; it holds at the last tap instead of wrapping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_index <= '0;
    end else if ((r_state == ST_IDLE) && i_start) begin
      r_index <= '0;
    end else if (w_accept && !w_last) begin
      r_index <= r_index + IDX_W'(1);
    end
  end

  // Shadow bank fill and atomic commit into the active bank
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow  <= '0;
      r_weights <= '0;
    end else begin
      if ((r_state == ST_LOAD) && i_abort) begin
        r_shadow <= '0;
      end else if (w_accept) begin
        r_shadow[r_index] <= iv_coeff;
      end
      if (r_state == ST_COMMIT) begin
        r_weights <= r_shadow;
      end
    end
  end

  assign o_coeff_ready = r_coeff_ready;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign ov_weights    = r_weights;

`ifdef FIR_COEFF_READBACK_EN
  logic signed [DATA_WIDTH-1:0] r_rd_data;

  // Registered readback of the active bank; addresses past the last tap read 0
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if ({1'b0, i_rd_addr} < (IDX_W + 1)'(NUM_TAPS)) begin
      r_rd_data <= $signed(r_weights[i_rd_addr]);
    end else begin
      r_rd_data <= '0;
    end
  end

  assign ov_rd_data = r_rd_data;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader (NUM_TAPS=4, DATA_WIDTH=8).
module tb_fir_coeff_loader;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_start;
  logic              i_abort;
  logic signed [7:0] iv_coeff;
  logic              i_coeff_valid;
  logic              o_coeff_ready;
  logic              o_busy;
  logic              o_done;
  logic [31:0]       ov_weights;
`ifdef FIR_COEFF_READBACK_EN
  logic [1:0]        i_rd_addr;
  logic signed [7:0] ov_rd_data;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int          ready_cnt = 0;
  bit          mon_en = 1'b0;
  logic [31:0] mon_active = '0;
  logic [31:0] mon_e;
  logic [31:0] exp_q[$];

  fir_coeff_loader #(.DATA_WIDTH(8), .NUM_TAPS(4)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .iv_coeff      (iv_coeff),
    .i_coeff_valid (i_coeff_valid),
    .o_coeff_ready (o_coeff_ready),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .ov_weights    (ov_weights)
`ifdef FIR_COEFF_READBACK_EN
    ,
    .i_rd_addr     (i_rd_addr),
    .ov_rd_data    (ov_rd_data)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the active bank may only change on an o_done cycle, to the next queued commit
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (o_coeff_ready) ready_cnt++;
      if (o_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("commit_weights", {32'd0, ov_weights}, {32'd0, mon_e});
          mon_active = mon_e;
        end
      end else begin
        chk("weights_hold", {32'd0, ov_weights}, {32'd0, mon_active});
      end
      if (o_coeff_ready) chk("ready_implies_busy", {63'd0, o_busy}, 64'd1);
    end
    if (i_rst) begin
      mon_active = '0;
      exp_q.delete();
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One load sequence; abort_at selects the beat (0..3) carrying i_abort, -1 for none.
  task automatic do_load(input logic [31:0] vals, input int gap_mode, input int abort_at,
                         input bit abort_valid);
    int g;
    ready_cnt = 0;
    i_start = 1'b1;
    i_abort = 1'($urandom_range(0, 1));
    tick();
    i_start = 1'b0;
    i_abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      for (int j = 0; j < g; j++) begin
        i_coeff_valid = 1'b0;
        iv_coeff      = 8'($urandom);
        i_start       = 1'($urandom_range(0, 1));
        tick();
        i_start = 1'b0;
      end
      chk("ready_in_load", {63'd0, o_coeff_ready}, 64'd1);
      iv_coeff = vals[k*8 +: 8];
      if (k == abort_at) begin
        i_coeff_valid = abort_valid;
        i_abort       = 1'b1;
        tick();
        i_abort       = 1'b0;
        i_coeff_valid = 1'b0;
        chk("abort_idle", {61'd0, o_busy, o_coeff_ready, o_done}, 64'd0);
        tick();
        tick();
        return;
      end
      i_coeff_valid = 1'b1;
      if (k == 3) exp_q.push_back(vals);
      tick();
      i_coeff_valid = 1'b0;
    end
    chk("commit_state", {61'd0, o_busy, o_coeff_ready, o_done}, 64'b100);
    i_abort = 1'($urandom_range(0, 1));
    i_start = 1'($urandom_range(0, 1));
    tick();
    i_abort = 1'b0;
    i_start = 1'b0;
    chk("done_pulse", {61'd0, o_busy, o_coeff_ready, o_done}, 64'b001);
  endtask

  initial begin
    int ab;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;
    iv_coeff = '0;
    i_coeff_valid = 1'b0;
`ifdef FIR_COEFF_READBACK_EN
    i_rd_addr = '0;
`endif
    tick();
    tick();
    i_rst = 1'b0;
    chk("reset_status", {61'd0, o_busy, o_coeff_ready, o_done}, 64'd0);
    chk("reset_weights", {32'd0, ov_weights}, 64'd0);
    mon_en = 1'b1;

    do_load(32'h40302010, 0, -1, 1'b0);
    chk("ready_cycles", ready_cnt, 64'd4);
    chk("first_load", {32'd0, ov_weights}, 64'h40302010);
    do_load(32'($urandom), 2, -1, 1'b0);
    do_load(32'h40302010, 1, -1, 1'b0);
    chk("toggle_load", {32'd0, ov_weights}, 64'h40302010);

    do_load(32'h00000201, 0, 2, 1'b0);
    chk("abort_keeps", {32'd0, ov_weights}, 64'h40302010);
    do_load(32'h7F030201, 0, 3, 1'b1);
    chk("abort_last_beat", {32'd0, ov_weights}, 64'h40302010);

    for (int n = 0; n < 25; n++) begin
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_load(32'($urandom), 2, ab, 1'($urandom_range(0, 1)));
    end

`ifdef FIR_COEFF_READBACK_EN
    do_load(32'h7F00FF80, 0, -1, 1'b0);
    i_rd_addr = 2'd1;
    tick();
    chk("readback_1", {56'd0, ov_rd_data}, 64'hFF);
    i_rd_addr = 2'd3;
    tick();
    chk("readback_3", {56'd0, ov_rd_data}, 64'h7F);
    i_rd_addr = 2'd0;
    tick();
    chk("readback_0", {56'd0, ov_rd_data}, 64'h80);
`endif

    do_load(32'hA55A3CC3, 2, -1, 1'b0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_coeff_valid = 1'b1;
    iv_coeff = 8'h11;
    tick();
    iv_coeff = 8'h22;
    tick();
    i_rst = 1'b1;
    i_start = 1'b1;
    i_abort = 1'b1;
    tick();
    i_rst = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_coeff_valid = 1'b0;
    chk("midload_reset_status", {61'd0, o_busy, o_coeff_ready, o_done}, 64'd0);
    chk("midload_reset_weights", {32'd0, ov_weights}, 64'd0);
    tick();
    tick();
    do_load(32'h0BADCAFE, 0, -1, 1'b0);
    chk("post_reset_load", {32'd0, ov_weights}, 64'h0BADCAFE);

    tick();
    tick();
    chk("queue_empty", exp_q.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 24: coefficient width, signed Q1.(DATA_WIDTH-1).
REQ-002 Parameter NUM_TAPS, default 8: number of filter taps (>=2).
REQ-003 i_clk  input  1  sole clock, all logic on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_start  input  1  begin a load sequence (sampled in IDLE only).
REQ-006 i_abort  input  1  abandon an in-progress load.
REQ-007 iv_coeff  input  DATA_WIDTH signed  coefficient beat.
REQ-008 i_coeff_valid  input  1  iv_coeff valid.
REQ-009 o_coeff_ready  output  1  loader accepts a beat.
REQ-010 o_busy  output  1  high in LOAD and COMMIT.
REQ-011 o_done  output  1  one-cycle pulse after commit.
REQ-012 ov_weights  output  NUM_TAPS*DATA_WIDTH  active weight bank; tap k at bits [k*DATA_WIDTH +: DATA_WIDTH], fed to the taps' iv_weight.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, COMMIT; all outputs registered.
REQ-014 IDLE: i_start=1 -> LOAD next cycle, beat index cleared to 0; otherwise stay.
REQ-015 o_coeff_ready SHALL be 1 exactly while state is LOAD; 0 in IDLE and COMMIT.
REQ-016 Beat accepted on an edge where i_coeff_valid && o_coeff_ready; iv_coeff written to shadow[index], index incremented; no acceptance without valid.
REQ-017 First accepted beat SHALL be tap 0, last (NUM_TAPS-th) beat tap NUM_TAPS-1.
REQ-018 Acceptance of beat NUM_TAPS-1 at edge N -> COMMIT during cycle N+1; at edge N+1 shadow copied to ov_weights in full, state -> IDLE, o_done=1 during cycle N+2 only.
REQ-019 ov_weights SHALL change only at the commit edge, all taps atomically; filter may keep running during LOAD.
REQ-020 i_abort=1 in LOAD -> IDLE next cycle, shadow discarded, ov_weights unchanged, no o_done; abort SHALL win over a simultaneous last beat.
REQ-021 i_abort in IDLE or COMMIT SHALL be ignored (commit completes).
REQ-022 i_start in LOAD or COMMIT SHALL be ignored; i_start on the o_done cycle (state IDLE) SHALL start a new load.
REQ-023 Index SHALL never wrap: no beat accepted after NUM_TAPS-th within one load.

Reset
REQ-024 i_rst=1 SHALL force state IDLE, index 0, shadow and ov_weights all 0, o_coeff_ready=0, o_busy=0, o_done=0 on the next edge.
REQ-025 Reset mid-LOAD or in COMMIT SHALL discard the load; reset SHALL override start, abort and beats in the same cycle.

Configuration
REQ-026 Macro FIR_COEFF_READBACK_EN defined: extra ports i_rd_addr (input, $clog2(NUM_TAPS)) and ov_rd_data (output, DATA_WIDTH signed); ov_rd_data = active weight at i_rd_addr, registered, 1-cycle latency; out-of-range address returns 0; reset value 0.
REQ-027 Macro undefined: readback ports and logic absent; all other behaviour identical.

Verification (bench NUM_TAPS=4, DATA_WIDTH=8)
REQ-028 Reset, pulse i_start, valid held high with 0x10,0x20,0x30,0x40 -> ready high 4 cycles, o_done one cycle after COMMIT, ov_weights=0x40302010.
REQ-029 Same load with valid toggling every other cycle -> only valid beats taken, same final ov_weights, ov_weights stays previous value until commit edge.
REQ-030 Load 0x01,0x02 then i_abort -> IDLE next cycle, ov_weights still 0x40302010, no o_done.
REQ-031 i_abort coincident with 4th beat 0x7F -> abort wins, ov_weights unchanged; i_rst mid-load -> ov_weights=0, all outputs 0.
REQ-032 With FIR_COEFF_READBACK_EN after load 0x80,0xFF,0x00,0x7F: i_rd_addr=1 -> ov_rd_data=0xFF one cycle later; addr 3 -> 0x7F.
